// File: rtl/fifo_rr_scheduler.sv
// Moves words from NF input FIFOs into one downstream FIFO, one pop per cycle.
// Defining ARB_STRICT_PRIO_EN replaces round-robin with fixed lowest-index priority.
module fifo_rr_scheduler #(
  parameter int NF     = 4,
  parameter int DATA_W = 8,
  parameter int TH_W   = 4,
  parameter int AF_DEF = 3,
  parameter int AE_DEF = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [TH_W-1:0]      umbral_af_in,
  input  logic [TH_W-1:0]      umbral_ae_in,
  input  logic [NF-1:0]        empty_in,
  input  logic [NF*DATA_W-1:0] data_in,
  input  logic                 almost_full_in,
  input  logic                 overflow_in,
  output logic [NF-1:0]        pop,
  output logic                 push,
  output logic [DATA_W-1:0]    data_out,
  output logic [TH_W-1:0]      umbral_af,
  output logic [TH_W-1:0]      umbral_ae,
  output logic                 pausa,
  output logic                 error_full,
  output logic [2:0]           state
);

  localparam int IDX_W = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [IDX_W:0]   NF_L   = (IDX_W+1)'(NF);
  localparam logic [IDX_W-1:0] LAST_L = IDX_W'(NF - 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TH_W-1:0]   umbral_af_q, umbral_af_d;
  logic [TH_W-1:0]   umbral_ae_q, umbral_ae_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              inflight_q, inflight_d;
  logic [IDX_W-1:0]  inflight_idx_q, inflight_idx_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              pausa_q, pausa_d;
  logic              error_full_q, error_full_d;

  logic [DATA_W-1:0] data_arr [NF];
  logic [NF-1:0]     req;
  logic [NF-1:0]     req_rot;
  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  offset;
  logic [IDX_W:0]    grant_sum;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_vld;
  logic [NF-1:0]     grant_oh;
  logic [NF-1:0]     pop_d;
  logic              pop_any;

  generate
    for (genvar gi = 0; gi < NF; gi++) begin : g_lane
      assign data_arr[gi] = data_in[gi*DATA_W +: DATA_W];
      assign grant_oh[gi] = grant_vld && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  assign req       = ~empty_in;
  assign grant_vld = |req;

`ifdef ARB_STRICT_PRIO_EN
  assign base = '0;
`else
  assign base = rr_q;
`endif

  // Rotate requests so the search always starts at bit 0, then map back.
  assign req_rot   = (req >> base) | (req << (NF_L - {1'b0, base}));
  assign grant_sum = {1'b0, base} + {1'b0, offset};
  assign grant_idx = (grant_sum >= NF_L) ? IDX_W'(grant_sum - NF_L)
                                         : grant_sum[IDX_W-1:0];

  always_comb begin
    offset = '0;
    for (int k = NF - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = IDX_W'(k);
    end
  end

  always_comb begin
    state_d        = state_q;
    umbral_af_d    = umbral_af_q;
    umbral_ae_d    = umbral_ae_q;
    rr_d           = rr_q;
    inflight_d     = 1'b0;
    inflight_idx_d = inflight_idx_q;
    push_d         = 1'b0;
    data_out_d     = data_out_q;
    pop_d          = '0;

    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)           state_d = ST_INIT;
        else if (grant_vld) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                            state_d = ST_INIT;
        else if (!grant_vld && !inflight_q)  state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
    if (state_q != ST_RESET && overflow_in) state_d = ST_ERROR;

    if (state_q == ST_INIT) begin
      umbral_af_d = umbral_af_in;
      umbral_ae_d = umbral_ae_in;
    end

    if (state_q == ST_ACTIVE && !almost_full_in) pop_d = grant_oh;
    pop_any = |pop_d;

    if (pop_any) begin
      inflight_d     = 1'b1;
      inflight_idx_d = grant_idx;
`ifdef ARB_STRICT_PRIO_EN
      rr_d = '0;
`else
      rr_d = (grant_idx == LAST_L) ? '0 : grant_idx + 1'b1;
`endif
    end

    // A word already popped is delivered unless the block is about to park in ERROR.
    if (inflight_q && state_d != ST_ERROR) begin
      push_d     = 1'b1;
      data_out_d = data_arr[inflight_idx_q];
    end

    pausa_d      = (state_q == ST_ACTIVE) && almost_full_in;
    error_full_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_RESET;
      umbral_af_q    <= TH_W'(AF_DEF);
      umbral_ae_q    <= TH_W'(AE_DEF);
      rr_q           <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      push_q         <= 1'b0;
      data_out_q     <= '0;
      pausa_q        <= 1'b0;
      error_full_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      umbral_af_q    <= umbral_af_d;
      umbral_ae_q    <= umbral_ae_d;
      rr_q           <= rr_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      push_q         <= push_d;
      data_out_q     <= data_out_d;
      pausa_q        <= pausa_d;
      error_full_q   <= error_full_d;
    end
  end

  assign pop        = pop_d;
  assign push       = push_q;
  assign data_out   = data_out_q;
  assign umbral_af  = umbral_af_q;
  assign umbral_ae  = umbral_ae_q;
  assign pausa      = pausa_q;
  assign error_full = error_full_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler; expectations are hand-derived cycle by cycle.
module tb_fifo_rr_scheduler;
  localparam int NF = 4, DATA_W = 8, TH_W = 4;
`ifdef ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 init;
  logic [TH_W-1:0]      umbral_af_in, umbral_ae_in;
  logic [NF-1:0]        empty_in;
  logic [NF*DATA_W-1:0] data_in;
  logic                 almost_full_in, overflow_in;
  logic [NF-1:0]        pop;
  logic                 push;
  logic [DATA_W-1:0]    data_out;
  logic [TH_W-1:0]      umbral_af, umbral_ae;
  logic                 pausa, error_full;
  logic [2:0]           state;

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_rr_scheduler #(.NF(NF), .DATA_W(DATA_W), .TH_W(TH_W), .AF_DEF(3), .AE_DEF(1)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_af_in(umbral_af_in), .umbral_ae_in(umbral_ae_in),
    .empty_in(empty_in), .data_in(data_in),
    .almost_full_in(almost_full_in), .overflow_in(overflow_in),
    .pop(pop), .push(push), .data_out(data_out),
    .umbral_af(umbral_af), .umbral_ae(umbral_ae),
    .pausa(pausa), .error_full(error_full), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("chk %-12s got=%0h ok", tag, got);
    end else begin
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0; init = 1'b0;
    umbral_af_in = 4'd12; umbral_ae_in = 4'd2;
    empty_in = 4'hF; data_in = 32'hD0C0B0A0;
    almost_full_in = 1'b0; overflow_in = 1'b0;

    // Reset
    tick(); tick(); settle();
    check("rst_state", state, 0);
    check("rst_af", umbral_af, 3);
    check("rst_ae", umbral_ae, 1);
    check("rst_pop", pop, 0);
    check("rst_push", push, 0);
    check("rst_dout", data_out, 0);
    check("rst_err", error_full, 0);
    reset = 1'b1;
    tick(); settle();
    check("st_init", state, 1);
    check("af_pre_load", umbral_af, 3);

    // Threshold load
    init = 1'b1;
    tick(); settle();
    check("init_af", umbral_af, 12);
    check("init_ae", umbral_ae, 2);
    check("st_init2", state, 1);
    init = 1'b0;
    tick(); settle();
    check("st_idle", state, 2);
    umbral_af_in = 4'd5; umbral_ae_in = 4'd5;
    tick(); settle();
    check("af_held", umbral_af, 12);
    check("ae_held", umbral_ae, 2);

    // Round-robin burst over inputs 0 and 2
    empty_in = 4'b1010; settle();
    check("idle_pop", pop, 0);
    tick(); settle();
    check("st_active", state, 3);
    check("pop_t0", pop, 4'b0001);
    tick(); settle();
    check("pop_t1", pop, STRICT ? 4'b0001 : 4'b0100);
    check("push_t1", push, 0);
    tick(); settle();
    check("pop_t2", pop, 4'b0001);
    check("push_t2", push, 1);
    check("dout_t2", data_out, 8'hA0);
    tick(); settle();
    check("pop_t3", pop, STRICT ? 4'b0001 : 4'b0100);
    check("push_t3", push, 1);
    check("dout_t3", data_out, STRICT ? 8'hA0 : 8'hC0);

    // Downstream almost-full mid-burst
    tick(); almost_full_in = 1'b1; settle();
    check("pop_af_t4", pop, 0);
    check("push_t4", push, 1);
    check("dout_t4", data_out, 8'hA0);
    tick(); settle();
    check("push_t5", push, 1);
    check("dout_t5", data_out, STRICT ? 8'hA0 : 8'hC0);
    check("pausa_t5", pausa, 1);
    check("pop_t5", pop, 0);
    tick(); almost_full_in = 1'b0; settle();
    check("push_t6", push, 0);
    check("dout_hold", data_out, STRICT ? 8'hA0 : 8'hC0);
    check("pausa_t6", pausa, 1);
    check("pop_resume", pop, 4'b0001);
    tick(); settle();
    check("pop_t7", pop, STRICT ? 4'b0001 : 4'b0100);
    check("pausa_t7", pausa, 0);
    check("push_t7", push, 0);

    // Overflow drops the in-flight word and parks in ERROR
    tick(); overflow_in = 1'b1; settle();
    check("push_t8", push, 1);
    check("dout_t8", data_out, 8'hA0);
    tick(); overflow_in = 1'b0; init = 1'b1; settle();
    check("st_error", state, 4);
    check("err_flag", error_full, 1);
    check("err_pop", pop, 0);
    check("err_push", push, 0);
    tick(); settle();
    check("err_stays", state, 4);
    check("err_push2", push, 0);
    check("err_af_frz", umbral_af, 12);
    reset = 1'b0; init = 1'b0;
    tick(); settle();
    check("rst2_state", state, 0);
    check("rst2_af", umbral_af, 3);
    reset = 1'b1;
    tick(); settle();
    check("rst2_init", state, 1);
    tick(); settle();
    check("rst2_idle", state, 2);
    check("rst2_af_ld", umbral_af, 5);

    // Arbitration order, then inputs draining with a word in flight
    tick(); settle();
    check("a0_state", state, 3);
    check("a0_pop", pop, 4'b0001);
    tick(); settle();
    check("a1_pop", pop, STRICT ? 4'b0001 : 4'b0100);
    tick(); settle();
    check("a2_pop", pop, 4'b0001);
    tick(); empty_in = 4'b1011; settle();
    check("a3_pop", pop, 4'b0100);
    tick(); empty_in = 4'b1111; settle();
    check("a4_pop", pop, 0);
    check("a4_dout", data_out, 8'hA0);
    tick(); settle();
    check("a5_state", state, 3);
    check("a5_push", push, 1);
    check("a5_dout", data_out, 8'hC0);
    tick(); settle();
    check("a6_state", state, 2);
    check("a6_push", push, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
